// File: rtl/full_subtractor_cell.sv
// One-bit full-subtractor cell: difference and borrow-out of a - b - bin.
// Purely combinational; chained by the core to form a ripple-borrow subtractor.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/full_subtractor_core.sv
// Registered WIDTH-bit ripple-borrow subtractor (a - b - bin) with borrow-out,
// result-valid flag and zero detect; one-cycle latency, one op per cycle.
module full_subtractor_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             out_valid,
    output logic             zero
);

    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_d;

    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_valid;
    logic             r_zero;

    assign w_br[0] = bin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            full_subtractor_cell u_cell (
                .a    (a[i]),
                .b    (b[i]),
                .bin  (w_br[i]),
                .d    (w_d[i]),
                .bout (w_br[i+1])
            );
        end
    endgenerate

    // Result registers hold across idle cycles; only the valid flag tracks in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_zero  <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_d    <= w_d;
                r_bout <= w_br[WIDTH];
                r_zero <= (w_d == '0);
            end
        end
    end

    assign d         = r_d;
    assign bout      = r_bout;
    assign out_valid = r_valid;
    assign zero      = r_zero;

endmodule

// File: tb/tb_full_subtractor_core.sv
// Directed bench for full_subtractor_core at WIDTH=1 (exhaustive truth table)
// and WIDTH=8 (underflow, normal, equal operands, valid gating, back-to-back).
module tb_full_subtractor_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic       a1, b1, bin1;
    logic       d1, bout1, ov1, z1;
    logic [7:0] a8, b8;
    logic       bin8;
    logic [7:0] d8;
    logic       bout8, ov8, z8;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    full_subtractor_core #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(vld),
        .a(a1), .b(b1), .bin(bin1),
        .d(d1), .bout(bout1), .out_valid(ov1), .zero(z1)
    );

    full_subtractor_core #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(vld),
        .a(a8), .b(b8), .bin(bin8),
        .d(d8), .bout(bout8), .out_valid(ov8), .zero(z8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] ed, input logic eb,
                        input logic ez, input logic ev);
        chk({tag, ".d"},    {24'h0, d8}, {24'h0, ed});
        chk({tag, ".bout"}, {31'h0, bout8}, {31'h0, eb});
        chk({tag, ".zero"}, {31'h0, z8},    {31'h0, ez});
        chk({tag, ".ov"},   {31'h0, ov8},   {31'h0, ev});
    endtask

    // WIDTH=1 truth table indexed by {A,B,Bin}.
    logic [7:0] tt_d    = 8'b1001_0110;
    logic [7:0] tt_bout = 8'b1000_1110;

    initial begin
        rst = 1'b1; vld = 1'b1;
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
        #1;
        step();
        step();
        // Reset dominates a coincident valid input.
        chk("rst1.d",    {31'h0, d1},    32'h0);
        chk("rst1.bout", {31'h0, bout1}, 32'h0);
        chk("rst1.zero", {31'h0, z1},    32'h1);
        chk("rst1.ov",   {31'h0, ov1},   32'h0);
        chk8("rst8", 8'h00, 1'b0, 1'b1, 1'b0);

        // Exhaustive WIDTH=1, back-to-back with a check after every edge.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; bin1 = v[0];
            step();
            chk($sformatf("tt%0d.d", i),    {31'h0, d1},    {31'h0, tt_d[i]});
            chk($sformatf("tt%0d.bout", i), {31'h0, bout1}, {31'h0, tt_bout[i]});
            chk($sformatf("tt%0d.zero", i), {31'h0, z1},    {31'h0, ~tt_d[i]});
            chk($sformatf("tt%0d.ov", i),   {31'h0, ov1},   32'h1);
        end

        // WIDTH=8: three consecutive valid ops, results on consecutive cycles.
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
        step();
        chk8("norm0", 8'h1E, 1'b0, 1'b0, 1'b1);
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b1;
        step();
        chk8("norm1", 8'h1D, 1'b0, 1'b0, 1'b1);
        a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
        step();
        chk8("under", 8'h00, 1'b1, 1'b1, 1'b1);

        // Valid gating: operands change while idle, outputs hold, ov drops.
        vld = 1'b0; a8 = 8'h11; b8 = 8'h01; bin8 = 1'b0;
        step();
        chk8("hold0", 8'h00, 1'b1, 1'b1, 1'b0);
        step();
        chk8("hold1", 8'h00, 1'b1, 1'b1, 1'b0);

        // Equal operands, then a small underflow with nonzero result.
        vld = 1'b1; a8 = 8'h77; b8 = 8'h77; bin8 = 1'b0;
        step();
        chk8("equal", 8'h00, 1'b0, 1'b1, 1'b1);
        a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0;
        step();
        chk8("wrap", 8'hFF, 1'b1, 1'b0, 1'b1);
        a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b1;
        step();
        chk8("big", 8'hE0, 1'b0, 1'b0, 1'b1);

        // Mid-stream reset with a valid input present.
        rst = 1'b1; a8 = 8'h01; b8 = 8'h02;
        step();
        chk8("rst8b", 8'h00, 1'b0, 1'b1, 1'b0);
        rst = 1'b0; vld = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
